// File: rtl/issue_ctrl_pkg.sv
// Shared RV32 decode helpers: opcode constants, field slices and register-usage predicates.
// Reused by issue_ctrl, pair_hazard_check and the decode stage.
package issue_ctrl_pkg;

  localparam int INSTR_W = 32;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  function automatic logic [6:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[6:0];
  endfunction

  function automatic logic [4:0] rd_of(input logic [INSTR_W-1:0] instr);
    return instr[11:7];
  endfunction

  function automatic logic [4:0] rs1_of(input logic [INSTR_W-1:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [INSTR_W-1:0] instr);
    return instr[24:20];
  endfunction

  function automatic logic uses_rs1(input logic [INSTR_W-1:0] instr);
    case (opcode_of(instr))
      OP_LUI, OP_AUIPC, OP_JAL: return 1'b0;
      default:                  return 1'b1;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [INSTR_W-1:0] instr);
    case (opcode_of(instr))
      OP_OP, OP_STORE, OP_BRANCH: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [INSTR_W-1:0] instr);
    case (opcode_of(instr))
      OP_STORE, OP_BRANCH: return 1'b0;
      default:             return 1'b1;
    endcase
  endfunction

  function automatic logic is_ctrl(input logic [INSTR_W-1:0] instr);
    case (opcode_of(instr))
      OP_BRANCH, OP_JAL, OP_JALR: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

  function automatic logic is_alu_only(input logic [INSTR_W-1:0] instr);
    case (opcode_of(instr))
      OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  // True when instr sources register r through an operand it actually reads.
  function automatic logic reads_reg(input logic [INSTR_W-1:0] instr, input logic [4:0] r);
    return (uses_rs1(instr) && (rs1_of(instr) == r)) ||
           (uses_rs2(instr) && (rs2_of(instr) == r));
  endfunction

endpackage

// File: rtl/issue_ctrl_pair_hazard_check.sv
// Purely combinational dual-issue pairing check and load-use detection
// against the load currently held in decode lane A.
module pair_hazard_check
  import issue_ctrl_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_a,
  input  logic [INSTR_W-1:0] instr_b,
  input  logic [INSTR_W-1:0] instr_ad,
  input  logic               valid_ad,
  output logic               pair,
  output logic               loaduse
);

  logic [4:0] a_rd_s;
  logic [4:0] ld_rd_s;
  logic       raw_s;
  logic       waw_s;
  logic       ld_in_d_s;

  assign a_rd_s    = rd_of(instr_a);
  assign raw_s     = writes_rd(instr_a) && (a_rd_s != 5'd0) && reads_reg(instr_b, a_rd_s);
  assign waw_s     = (rd_of(instr_b) == a_rd_s) && (a_rd_s != 5'd0);
  assign pair      = !is_ctrl(instr_a) && is_alu_only(instr_b) && !raw_s && !waw_s;

  // Only a valid load with a real destination can create a load-use bubble.
  assign ld_rd_s   = rd_of(instr_ad);
  assign ld_in_d_s = valid_ad && (opcode_of(instr_ad) == OP_LOAD) && (ld_rd_s != 5'd0);
  assign loaduse   = ld_in_d_s &&
                     (reads_reg(instr_a, ld_rd_s) || (pair && reads_reg(instr_b, ld_rd_s)));

endmodule

// File: rtl/issue_ctrl.sv
// Dual-issue controller: fetch/decode pipeline register, load-use interlock and fetch steering.
// Optional performance counters are built when ISSUE_PERF_CNT_EN is defined.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] InstrA,
  input  logic [DATA_WIDTH-1:0] InstrB,
  input  logic                  StallD,
  input  logic                  FlushD,
  output logic                  PCSrc,
  output logic                  IncrSrc,
  output logic [DATA_WIDTH-1:0] InstrAD,
  output logic [DATA_WIDTH-1:0] InstrBD,
  output logic                  ValidAD,
`ifdef ISSUE_PERF_CNT_EN
  output logic                  ValidBD,
  output logic [31:0]           DualCnt,
  output logic [31:0]           SingleCnt,
  output logic [31:0]           StallCnt
`else
  output logic                  ValidBD
`endif
);

  logic [DATA_WIDTH-1:0] instr_ad_r;
  logic [DATA_WIDTH-1:0] instr_bd_r;
  logic                  valid_ad_r;
  logic                  valid_bd_r;
  logic                  pair_s;
  logic                  loaduse_s;
  logic                  hold_s;
  logic                  pcsrc_s;
  logic                  incrsrc_s;

  pair_hazard_check u_pair_hazard_check (
    .instr_a  (InstrA),
    .instr_b  (InstrB),
    .instr_ad (instr_ad_r),
    .valid_ad (valid_ad_r),
    .pair     (pair_s),
    .loaduse  (loaduse_s)
  );

  assign hold_s = StallD | loaduse_s;

  // Fetch steering: hold PC on any hold, advance by 8 only on a pair issue; quiet in reset.
  always_comb begin
    pcsrc_s   = 1'b0;
    incrsrc_s = 1'b0;
    if (rst) begin
      pcsrc_s   = 1'b0;
      incrsrc_s = 1'b0;
    end else begin
      pcsrc_s   = hold_s;
      incrsrc_s = pair_s & ~hold_s;
    end
  end

  assign PCSrc   = pcsrc_s;
  assign IncrSrc = incrsrc_s;

  // Decode-stage registers; flush beats stall, stall beats the load-use bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_ad_r <= '0;
      instr_bd_r <= '0;
      valid_ad_r <= 1'b0;
      valid_bd_r <= 1'b0;
    end else if (FlushD) begin
      instr_ad_r <= '0;
      instr_bd_r <= '0;
      valid_ad_r <= 1'b0;
      valid_bd_r <= 1'b0;
    end else if (StallD) begin
      instr_ad_r <= instr_ad_r;
      instr_bd_r <= instr_bd_r;
      valid_ad_r <= valid_ad_r;
      valid_bd_r <= valid_bd_r;
    end else if (loaduse_s) begin
      instr_ad_r <= '0;
      instr_bd_r <= '0;
      valid_ad_r <= 1'b0;
      valid_bd_r <= 1'b0;
    end else begin
      instr_ad_r <= InstrA;
      instr_bd_r <= pair_s ? InstrB : '0;
      valid_ad_r <= 1'b1;
      valid_bd_r <= pair_s;
    end
  end

  assign InstrAD = instr_ad_r;
  assign InstrBD = instr_bd_r;
  assign ValidAD = valid_ad_r;
  assign ValidBD = valid_bd_r;

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] dual_cnt_r;
  logic [31:0] single_cnt_r;
  logic [31:0] stall_cnt_r;

  // Exactly one counter advances on each non-reset, non-flush edge; natural 32-bit wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      dual_cnt_r   <= 32'd0;
      single_cnt_r <= 32'd0;
      stall_cnt_r  <= 32'd0;
    end else if (FlushD) begin
      dual_cnt_r   <= dual_cnt_r;
      single_cnt_r <= single_cnt_r;
      stall_cnt_r  <= stall_cnt_r;
    end else if (hold_s) begin
      stall_cnt_r  <= stall_cnt_r + 32'd1;
    end else if (pair_s) begin
      dual_cnt_r   <= dual_cnt_r + 32'd1;
    end else begin
      single_cnt_r <= single_cnt_r + 32'd1;
    end
  end

  assign DualCnt   = dual_cnt_r;
  assign SingleCnt = single_cnt_r;
  assign StallCnt  = stall_cnt_r;
`endif

endmodule
